// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: depth computation, Gray/binary conversion and the
// read output-stage state type. Used by both pointer domains and the memory.
package fifo_pkg;

    // Widest pointer the conversion helpers handle; narrower pointers are
    // zero-extended on the way in and truncated on the way out.
    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    // Read output stage: EMPTY holds nothing, HOLD presents a valid word.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_e;

    // Number of memory words addressed by an address_bits-wide address.
    function automatic int unsigned fifo_depth(input int unsigned address_bits);
        return 32'd1 << address_bits;
    endfunction

    // Binary to Gray for any width up to GRAY_MAX_W (upper bits zero).
    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary for any width up to GRAY_MAX_W (upper bits zero):
    // each binary bit is the XOR of all Gray bits at or above it.
    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Read-side bundle of the async FIFO: synchronized write pointer in, memory
// address/data, Gray read pointer out, status flags and the consumer handshake.
interface fifo_read_ctrl_if #(
    parameter int DATASIZE     = 8,
    parameter int ADDRESS_BITS = 4
);
    logic [ADDRESS_BITS:0]   sync_write_ptr;
    logic [ADDRESS_BITS-1:0] read_addr;
    logic [DATASIZE-1:0]     mem_read_data;
    logic [ADDRESS_BITS:0]   read_ptr;
    logic                    read_empty;
    logic                    read_almost_empty;
    logic [ADDRESS_BITS:0]   read_level;
    logic [DATASIZE-1:0]     read_data;
    logic                    read_valid;
    logic                    read_ready;

    // Controller side.
    modport master (
        input  sync_write_ptr, mem_read_data, read_ready,
        output read_addr, read_ptr, read_empty, read_almost_empty,
               read_level, read_data, read_valid
    );

    // Memory, synchronizer and consumer side.
    modport slave (
        output sync_write_ptr, mem_read_data, read_ready,
        input  read_addr, read_ptr, read_empty, read_almost_empty,
               read_level, read_data, read_valid
    );
endinterface

// File: rtl/fifo_read_out_stage.sv
// Registered valid/ready output stage: captures the memory word on every pop
// and presents it until the consumer takes it.
module fifo_read_out_stage
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                read_clk,
    input  logic                read_rst,
    input  logic                pop,
    input  logic                read_ready,
    input  logic [DATASIZE-1:0] mem_read_data,
    output logic [DATASIZE-1:0] read_data,
    output logic                read_valid
);

    out_state_e state;

    // Load on pop (EMPTY->HOLD or HOLD->HOLD), release on a take without pop.
    always_ff @(posedge read_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (read_rst) begin
            state     <= OUT_EMPTY;
            // NOTE: the data register is reset too, so a discarded word never
            // reappears on read_data after a mid-stream reset.
            read_data <= '0;
        end else if (pop) begin
            state     <= OUT_HOLD;
            read_data <= mem_read_data;
        end else if (state == OUT_HOLD && read_ready) begin
            state     <= OUT_EMPTY;
        end
    end

    assign read_valid = (state == OUT_HOLD);

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the async FIFO: binary/Gray read pointers, memory
// address, empty/almost-empty/level flags and the registered output stage.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int DATASIZE           = 8,
    parameter int ADDRESS_BITS       = 4,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic              read_clk,
    input  logic              read_rst,
    fifo_read_ctrl_if.master  rif
);

    localparam int          PW    = ADDRESS_BITS + 1;
    localparam int unsigned DEPTH = fifo_depth(ADDRESS_BITS);
    // A threshold above DEPTH would make the flag constant; clamp it.
    localparam int unsigned AE_LEVEL =
        (ALMOST_EMPTY_LEVEL > int'(DEPTH)) ? DEPTH : ALMOST_EMPTY_LEVEL;
    localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic          pop;

    // A word leaves memory whenever one is there and the stage can take it.
    assign pop        = !rif.read_empty && (!rif.read_valid || rif.read_ready);
    assign rbin_next  = rbin + PW'(pop);
    assign rgray_next = PW'(bin2gray(gray_word_t'(rbin_next)));
    assign wbin       = PW'(gray2bin(gray_word_t'(rif.sync_write_ptr)));
    // The extra pointer MSB makes the modular difference cover 0..DEPTH.
    assign level_next = wbin - rbin_next;

    assign rif.read_addr = rbin[ADDRESS_BITS-1:0];

    // Pointer and flag registers, all computed from the post-pop pointer so
    // the last pop raises read_empty at the same edge.
    always_ff @(posedge read_clk) begin
        if (read_rst) begin
            rbin                  <= '0;
            rif.read_ptr          <= '0;
            rif.read_empty        <= 1'b1;
            rif.read_almost_empty <= 1'b1;
            rif.read_level        <= '0;
        end else begin
            rbin                  <= rbin_next;
            rif.read_ptr          <= rgray_next;
            rif.read_empty        <= (rgray_next == rif.sync_write_ptr);
            rif.read_almost_empty <= (level_next <= AE_THRESH);
            rif.read_level        <= level_next;
        end
    end

    fifo_read_out_stage #(
        .DATASIZE (DATASIZE)
    ) u_out_stage (
        .read_clk      (read_clk),
        .read_rst      (read_rst),
        .pop           (pop),
        .read_ready    (rif.read_ready),
        .mem_read_data (rif.mem_read_data),
        .read_data     (rif.read_data),
        .read_valid    (rif.read_valid)
    );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: directed scenarios plus randomized
// traffic, compared every cycle against a word-count reference model.
module tb_fifo_read_ctrl;

    localparam int DW    = 8;
    localparam int AB    = 4;
    localparam int DEPTH = 16;
    localparam int AE    = 2;

    logic read_clk = 1'b0;
    logic read_rst;

    always #5 read_clk = ~read_clk;

    fifo_read_ctrl_if #(.DATASIZE(DW), .ADDRESS_BITS(AB)) rif ();

    fifo_read_ctrl #(
        .DATASIZE           (DW),
        .ADDRESS_BITS       (AB),
        .ALMOST_EMPTY_LEVEL (AE)
    ) dut (
        .read_clk (read_clk),
        .read_rst (read_rst),
        .rif      (rif.master)
    );

    // Memory array model: combinational read at the DUT's address.
    logic [DW-1:0] mem [DEPTH];
    assign rif.mem_read_data = mem[rif.read_addr];

    // Reference model: total words written and popped, plus the output stage.
    int            wr_total;
    int            rd_total;
    int            m_level;
    bit            m_empty;
    bit            m_ae;
    bit            m_valid;
    logic [DW-1:0] m_data;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AB:0] gray5(input int n);
        logic [AB:0] b;
        b = (AB+1)'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic cmp_all();
        check("empty",    32'(rif.read_empty),        32'(m_empty));
        check("a_empty",  32'(rif.read_almost_empty), 32'(m_ae));
        check("level",    32'(rif.read_level),        32'(m_level));
        check("ptr",      32'(rif.read_ptr),          32'(gray5(rd_total)));
        check("addr",     32'(rif.read_addr),         32'(rd_total % DEPTH));
        check("valid",    32'(rif.read_valid),        32'(m_valid));
        check("data",     32'(rif.read_data),         32'(m_data));
    endtask

    // One clock: update the model from pre-edge inputs, then compare.
    task automatic step();
        bit pop;
        @(posedge read_clk);
        if (read_rst) begin
            rd_total = 0;
            m_valid  = 1'b0;
            m_data   = '0;
            m_level  = 0;
        end else begin
            pop = !m_empty && (!m_valid || rif.read_ready);
            if (pop) begin
                m_data  = mem[rd_total % DEPTH];
                m_valid = 1'b1;
                rd_total++;
            end else if (m_valid && rif.read_ready) begin
                m_valid = 1'b0;
            end
            m_level = wr_total - rd_total;
        end
        m_empty = (m_level == 0);
        m_ae    = (m_level <= AE);
        #1;
        cmp_all();
        @(negedge read_clk);
    endtask

    // Write up to n words, never overrunning unread memory.
    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            if (wr_total - rd_total < DEPTH) begin
                mem[wr_total % DEPTH] = DW'($urandom);
                wr_total++;
            end
        end
        rif.sync_write_ptr = gray5(wr_total);
    endtask

    task automatic apply_reset();
        read_rst           = 1'b1;
        wr_total           = 0;
        rif.sync_write_ptr = '0;
        rif.read_ready     = 1'b0;
        step();
        step();
        read_rst = 1'b0;
    endtask

    initial begin
        read_rst           = 1'b1;
        rif.read_ready     = 1'b0;
        rif.sync_write_ptr = '0;
        wr_total = 0;
        rd_total = 0;
        m_level  = 0;
        m_empty  = 1'b1;
        m_ae     = 1'b1;
        m_valid  = 1'b0;
        m_data   = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset state.
        apply_reset();
        check("rst_empty", 32'(rif.read_empty), 32'd1);
        check("rst_ae",    32'(rif.read_almost_empty), 32'd1);
        check("rst_valid", 32'(rif.read_valid), 32'd0);
        check("rst_ptr",   32'(rif.read_ptr), 32'd0);
        check("rst_level", 32'(rif.read_level), 32'd0);
        step();

        // Single word with first-word latency.
        mem[0]             = 8'hA5;
        wr_total           = 1;
        rif.sync_write_ptr = gray5(1);
        step();
        check("single_empty_fall", 32'(rif.read_empty), 32'd0);
        check("single_valid_wait", 32'(rif.read_valid), 32'd0);
        step();
        check("single_valid", 32'(rif.read_valid), 32'd1);
        check("single_data",  32'(rif.read_data), 32'hA5);
        check("single_ptr",   32'(rif.read_ptr), 32'b00001);
        check("single_level", 32'(rif.read_level), 32'd0);
        step();

        // Backpressure: one pop only, then three back-to-back words.
        apply_reset();
        write_words(3);
        for (int i = 0; i < 5; i++) step();
        check("bp_addr",  32'(rif.read_addr), 32'd1);
        check("bp_level", 32'(rif.read_level), 32'd2);
        check("bp_data",  32'(rif.read_data), 32'(mem[0]));
        rif.read_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("bp_valid_fall", 32'(rif.read_valid), 32'd0);

        // Full memory, drain through the wrap, then continue past it.
        apply_reset();
        write_words(DEPTH);
        step();
        check("full_level", 32'(rif.read_level), 32'd16);
        check("full_ae",    32'(rif.read_almost_empty), 32'd0);
        rif.read_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step();
        check("wrap_ptr",   32'(rif.read_ptr), 32'b11000);
        check("wrap_empty", 32'(rif.read_empty), 32'd1);
        check("wrap_addr",  32'(rif.read_addr), 32'd0);
        write_words(1);
        for (int i = 0; i < 3; i++) step();
        check("wrap_addr_next", 32'(rif.read_addr), 32'd1);

        // Reset mid-stream with a buffered word.
        apply_reset();
        write_words(6);
        for (int i = 0; i < 3; i++) step();
        check("mid_valid", 32'(rif.read_valid), 32'd1);
        check("mid_level", 32'(rif.read_level), 32'd5);
        read_rst           = 1'b1;
        wr_total           = 0;
        rif.sync_write_ptr = '0;
        step();
        check("mid_rst_valid", 32'(rif.read_valid), 32'd0);
        check("mid_rst_data",  32'(rif.read_data), 32'd0);
        check("mid_rst_level", 32'(rif.read_level), 32'd0);
        check("mid_rst_empty", 32'(rif.read_empty), 32'd1);
        read_rst = 1'b0;

        // Randomized traffic with varying write bursts and consumer stalls.
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            int phase;
            phase          = (i / 250) % 4;
            rif.read_ready = (phase == 1) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 || phase == 2)
                write_words($urandom_range(0, 4));
            if ($urandom_range(0, 299) == 0) begin
                read_rst           = 1'b1;
                wr_total           = 0;
                rif.sync_write_ptr = '0;
            end
            step();
            read_rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
